ulpi_reg_engine: RTL and testbench
==================================

# ulpi_reg_engine

ULPI register access engine for immediate register reads and writes to the PHY. It sits beside `ulpi_ctrl` on the link side of the ULPI bus and starts only after `ulpi_ctrl` reports the PHY reset/startup sequence complete. It turns a single-request handshake from upper logic into the ULPI TX CMD / data / STP sequence, and returns read data plus a completion status.

## Interface
Parameters:
- `TIMEOUT_CYCLES`, default 255: maximum cycles spent waiting for `i_nxt` (TXCMD + WDATA combined) before a TIMEOUT completion. Used only with `ULPI_REG_TIMEOUT_EN`.

Ports:
- `i_clk` in 1: ULPI 60 MHz clock; single clock domain.
- `i_rst_n` in 1: reset, asynchronous, active-low.
- `i_link_ready` in 1: from `ulpi_ctrl`; high once the PHY startup sequence is done.
- `i_req_valid` in 1: request present.
- `o_req_ready` in 1 / out: request accepted when `i_req_valid & o_req_ready` are high.
- `i_req_write` in 1: 1 = register write, 0 = register read.
- `i_req_addr` in 6: immediate register address.
- `i_req_wdata` in 8: write data.
- `o_rsp_valid` out 1: one-cycle completion pulse; no backpressure.
- `o_rsp_status` out 2: OK=0, ABORT=1, TIMEOUT=2.
- `o_rsp_rdata` out 8: read data; valid with `o_rsp_valid` on OK reads, 0 otherwise.
- `i_dir`, `i_nxt` in 1: ULPI PHY signals.
- `i_data` in 8: ULPI data from PHY.
- `o_stp` out 1: ULPI STP.
- `o_data` out 8: ULPI data to PHY.
- `o_data_oe` out 1: link drives data bus.

## Operation
- All signals are sampled on rising `i_clk`. All outputs are registered.
- Reset value of every output is 0. State resets to IDLE.
- `o_req_ready` = 1 only when all hold: state IDLE, `i_link_ready`=1, `i_dir`=0.
- On accept, the engine latches addr, wdata and write flag.
- States and behaviour:
  - **IDLE**: waits for an accepted request, then goes to TXCMD.
  - **TXCMD**: `o_data` = `{2'b10,addr}` for a write or `{2'b11,addr}` for a read; `o_data_oe`=1.
    - Sampled `i_dir`=1 → WAIT_DIR_LOW, with the retry flag set.
    - Sampled `i_nxt`=1 with `i_dir`=0 → WDATA (write) or RD_TURN (read).
  - **WDATA**: `o_data` = wdata.
    - `i_nxt`=1 → STP.
    - `i_dir`=1 → ABORT completion via WAIT_DIR_LOW.
  - **STP**: `o_stp`=1 and `o_data`=0 for exactly one cycle → RSP(OK).
  - **RD_TURN**: `o_data_oe`=0. This is the turnaround cycle; `i_dir` is expected to be 1 by the end of it → RD_DATA.
  - **RD_DATA**:
    - `i_dir`=1 and `i_nxt`=0: capture `i_data` into rdata → RD_BACK.
    - `i_nxt`=1: an RX CMD/packet has pre-empted the read → ABORT via WAIT_DIR_LOW.
  - **RD_BACK**: waits for `i_dir`=0, then one turnaround cycle → RSP(OK).
  - **WAIT_DIR_LOW**: `o_data_oe`=0; waits for `i_dir`=0.
    - Retry flag set → TXCMD; TX CMD pre-emption is retried without limit except by timeout.
    - Retry flag clear → RSP(ABORT).
  - **RSP**: `o_rsp_valid`=1 for one cycle → IDLE.
- `i_link_ready` falling in any state forces IDLE on the next edge. No response is issued and `o_stp`/`o_data_oe` are driven to 0.
- Asynchronous reset mid-transaction drops the transaction with no response.

## Timing
- Write latency, accept to `o_rsp_valid`, with the PHY asserting `i_nxt` on the first cycle of TXCMD and of WDATA: 4 cycles (TXCMD, WDATA, STP, RSP).
- Read latency with an immediate `i_nxt`: 5 cycles (TXCMD, RD_TURN, RD_DATA, RD_BACK with `i_dir` already low, RSP).
- Back-to-back requests: the earliest next accept is the cycle after RSP.
- When `i_dir` and `i_nxt` are sampled high together in TXCMD, `i_dir` wins (pre-emption).

## Configuration
- `ULPI_REG_TIMEOUT_EN` defined:
  - A counter is cleared on accept and increments every cycle in TXCMD/WDATA.
  - Reaching `TIMEOUT_CYCLES` → `o_stp`=1 for one cycle, then RSP(TIMEOUT).
- `ULPI_REG_TIMEOUT_EN` undefined: no counter, TIMEOUT is never reported, and the engine waits indefinitely.

## Structure
- Shared package `ulpi_pkg` holds:
  - enum `ulpi_reg_state_t`;
  - enum `ulpi_reg_status_t` (OK/ABORT/TIMEOUT);
  - constants `ULPI_TXCMD_REGW`=2'b10 and `ULPI_TXCMD_REGR`=2'b11.
- One sub-module, `ulpi_timeout_cnt` (clear/enable/expired), instantiated only under `ULPI_REG_TIMEOUT_EN`.

## Test plan
- **Write, immediate nxt**: write addr 0x0A, data 0x55; PHY asserts `i_nxt` in TXCMD and WDATA → `o_data` 0x8A then 0x55, one-cycle `o_stp`, then `o_rsp_valid` with OK, 4 cycles after accept.
- **Read**: read addr 0x00; PHY gives `i_nxt`, then `i_dir`=1 with `i_data`=0x24 → `o_data`=0xC0, `o_rsp_rdata`=0x24, OK.
- **TX CMD pre-emption**: `i_dir`=1 during TXCMD for 3 cycles → `o_data_oe`=0, TXCMD re-issued after `i_dir` falls, final status OK.
- **Read abort**: `i_dir`=1 and `i_nxt`=1 in RD_DATA → ABORT, `o_rsp_rdata`=0.
- **Timeout** (`ULPI_REG_TIMEOUT_EN`, `TIMEOUT_CYCLES`=8, `i_nxt` held 0) → `o_stp` pulse, then TIMEOUT exactly 8 TXCMD cycles after entry.
- **Reset and link-ready gating**: `i_rst_n` low mid-WDATA → all outputs 0 asynchronously, state IDLE; `i_link_ready`=0 → `o_req_ready`=0.

Source files
------------

// File: rtl/ulpi_pkg.sv
// Shared ULPI types: register-engine FSM states, completion status codes and TX CMD prefixes.
package ulpi_pkg;

  typedef enum logic [3:0] {
    StIdle,
    StTxCmd,
    StWData,
    StStp,
    StRdTurn,
    StRdData,
    StRdBack,
    StWaitDirLow,
    StRsp
  } ulpi_reg_state_t;

  typedef enum logic [1:0] {
    RspOk      = 2'd0,
    RspAbort   = 2'd1,
    RspTimeout = 2'd2
  } ulpi_reg_status_t;

  localparam logic [1:0] ULPI_TXCMD_REGW = 2'b10;
  localparam logic [1:0] ULPI_TXCMD_REGR = 2'b11;

endpackage

// File: rtl/ulpi_timeout_cnt.sv
// Cycle counter for the register engine; expired_o flags the cycle whose increment reaches
// TimeoutCycles. Only instantiated when ULPI_REG_TIMEOUT_EN is defined.
module ulpi_timeout_cnt #(
  parameter int unsigned TimeoutCycles = 255
) (
  input  logic clk_i,
  input  logic rst_ni,
  input  logic clear_i,
  input  logic enable_i,
  output logic expired_o
);

  localparam int unsigned CntW = $clog2(TimeoutCycles + 1);
  localparam logic [CntW-1:0] CntLast = CntW'(TimeoutCycles - 1);
  localparam logic [CntW-1:0] CntMax  = CntW'(TimeoutCycles);

  logic [CntW-1:0] cnt_q, cnt_d;

  always_comb begin
    cnt_d = cnt_q;
    if (clear_i) begin
      cnt_d = '0;
    end else if (enable_i && (cnt_q != CntMax)) begin
      cnt_d = cnt_q + 1'b1;
    end
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      cnt_q <= '0;
    end else begin
      cnt_q <= cnt_d;
    end
  end

  assign expired_o = enable_i && (cnt_q >= CntLast);

endmodule

// File: rtl/ulpi_reg_engine.sv
// ULPI immediate register read/write engine: request handshake -> TX CMD / data / STP sequence.
// Optional TX-side timeout enabled by defining ULPI_REG_TIMEOUT_EN.
module ulpi_reg_engine
  import ulpi_pkg::*;
#(
  parameter int unsigned TIMEOUT_CYCLES = 255
) (
  input  logic       i_clk,
  input  logic       i_rst_n,
  input  logic       i_link_ready,
  input  logic       i_req_valid,
  output logic       o_req_ready,
  input  logic       i_req_write,
  input  logic [5:0] i_req_addr,
  input  logic [7:0] i_req_wdata,
  output logic       o_rsp_valid,
  output logic [1:0] o_rsp_status,
  output logic [7:0] o_rsp_rdata,
  input  logic       i_dir,
  input  logic       i_nxt,
  input  logic [7:0] i_data,
  output logic       o_stp,
  output logic [7:0] o_data,
  output logic       o_data_oe
);

  ulpi_reg_state_t  state_q, state_d;
  ulpi_reg_status_t status_q, status_d;
  logic             write_q, write_d;
  logic [5:0]       addr_q, addr_d;
  logic [7:0]       wdata_q, wdata_d;
  logic [7:0]       rdata_q, rdata_d;
  logic             retry_q, retry_d;

  logic             req_ready_q, req_ready_d;
  logic             rsp_valid_q, rsp_valid_d;
  logic [1:0]       rsp_status_q, rsp_status_d;
  logic [7:0]       rsp_rdata_q, rsp_rdata_d;
  logic             stp_q, stp_d;
  logic [7:0]       data_q, data_d;
  logic             data_oe_q, data_oe_d;

  logic accept;
  logic timeout_exp;

  assign accept = i_req_valid & req_ready_q & i_link_ready;

`ifdef ULPI_REG_TIMEOUT_EN
  logic timeout_en;
  assign timeout_en = (state_q == StTxCmd) || (state_q == StWData);

  ulpi_timeout_cnt #(
    .TimeoutCycles(TIMEOUT_CYCLES)
  ) u_timeout_cnt (
    .clk_i    (i_clk),
    .rst_ni   (i_rst_n),
    .clear_i  (accept),
    .enable_i (timeout_en),
    .expired_o(timeout_exp)
  );
`else
  logic [31:0] unused_timeout_cycles;
  assign unused_timeout_cycles = TIMEOUT_CYCLES;
  assign timeout_exp = 1'b0;
`endif

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      state_q  <= StIdle;
      status_q <= RspOk;
      write_q  <= 1'b0;
      addr_q   <= '0;
      wdata_q  <= '0;
      rdata_q  <= '0;
      retry_q  <= 1'b0;
    end else begin
      state_q  <= state_d;
      status_q <= status_d;
      write_q  <= write_d;
      addr_q   <= addr_d;
      wdata_q  <= wdata_d;
      rdata_q  <= rdata_d;
      retry_q  <= retry_d;
    end
  end

  always_comb begin
    state_d  = state_q;
    status_d = status_q;
    write_d  = write_q;
    addr_d   = addr_q;
    wdata_d  = wdata_q;
    rdata_d  = rdata_q;
    retry_d  = retry_q;
    case (state_q)
      StIdle: begin
        if (accept) begin
          state_d  = StTxCmd;
          status_d = RspOk;
          write_d  = i_req_write;
          addr_d   = i_req_addr;
          wdata_d  = i_req_wdata;
          rdata_d  = '0;
          retry_d  = 1'b0;
        end
      end
      StTxCmd: begin
        // PHY pre-emption beats a simultaneous nxt; the TX CMD is re-sent once dir drops.
        if (i_dir) begin
          state_d = StWaitDirLow;
          retry_d = 1'b1;
        end else if (i_nxt) begin
          state_d = write_q ? StWData : StRdTurn;
        end else if (timeout_exp) begin
          state_d  = StStp;
          status_d = RspTimeout;
        end
      end
      StWData: begin
        if (i_dir) begin
          state_d  = StWaitDirLow;
          retry_d  = 1'b0;
          status_d = RspAbort;
        end else if (i_nxt) begin
          state_d = StStp;
        end else if (timeout_exp) begin
          state_d  = StStp;
          status_d = RspTimeout;
        end
      end
      StStp:    state_d = StRsp;
      StRdTurn: state_d = StRdData;
      StRdData: begin
        if (i_nxt) begin
          state_d  = StWaitDirLow;
          retry_d  = 1'b0;
          status_d = RspAbort;
        end else if (i_dir) begin
          state_d = StRdBack;
          rdata_d = i_data;
        end
      end
      StRdBack: begin
        if (!i_dir) state_d = StRsp;
      end
      StWaitDirLow: begin
        if (!i_dir) state_d = retry_q ? StTxCmd : StRsp;
      end
      StRsp:    state_d = StIdle;
      default:  state_d = StIdle;
    endcase
    if (!i_link_ready) state_d = StIdle;
  end

  // Outputs are decoded from the next state so they line up with the state once registered.
  always_comb begin
    req_ready_d  = 1'b0;
    rsp_valid_d  = 1'b0;
    rsp_status_d = 2'd0;
    rsp_rdata_d  = '0;
    stp_d        = 1'b0;
    data_d       = '0;
    data_oe_d    = 1'b0;
    case (state_d)
      StIdle:  req_ready_d = i_link_ready & ~i_dir;
      StTxCmd: begin
        data_d    = {(write_d ? ULPI_TXCMD_REGW : ULPI_TXCMD_REGR), addr_d};
        data_oe_d = 1'b1;
      end
      StWData: begin
        data_d    = wdata_d;
        data_oe_d = 1'b1;
      end
      StStp: begin
        stp_d     = 1'b1;
        data_oe_d = 1'b1;
      end
      StRsp: begin
        rsp_valid_d  = 1'b1;
        rsp_status_d = status_d;
        if ((status_d == RspOk) && !write_d) rsp_rdata_d = rdata_d;
      end
      default: ;
    endcase
  end

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      req_ready_q  <= 1'b0;
      rsp_valid_q  <= 1'b0;
      rsp_status_q <= 2'd0;
      rsp_rdata_q  <= '0;
      stp_q        <= 1'b0;
      data_q       <= '0;
      data_oe_q    <= 1'b0;
    end else begin
      req_ready_q  <= req_ready_d;
      rsp_valid_q  <= rsp_valid_d;
      rsp_status_q <= rsp_status_d;
      rsp_rdata_q  <= rsp_rdata_d;
      stp_q        <= stp_d;
      data_q       <= data_d;
      data_oe_q    <= data_oe_d;
    end
  end

  assign o_req_ready  = req_ready_q;
  assign o_rsp_valid  = rsp_valid_q;
  assign o_rsp_status = rsp_status_q;
  assign o_rsp_rdata  = rsp_rdata_q;
  assign o_stp        = stp_q;
  assign o_data       = data_q;
  assign o_data_oe    = data_oe_q;

endmodule

// File: tb/tb_ulpi_reg_engine.sv
// Directed bench for ulpi_reg_engine; define ULPI_REG_TIMEOUT_EN to also cover the timeout path.
module tb_ulpi_reg_engine;

  logic       clk;
  logic       rst_n;
  logic       link_ready;
  logic       req_valid;
  logic       req_ready;
  logic       req_write;
  logic [5:0] req_addr;
  logic [7:0] req_wdata;
  logic       rsp_valid;
  logic [1:0] rsp_status;
  logic [7:0] rsp_rdata;
  logic       dir;
  logic       nxt;
  logic [7:0] data_in;
  logic       stp;
  logic [7:0] data_out;
  logic       data_oe;

  int n_checks = 0;
  int n_errors = 0;

  ulpi_reg_engine #(
    .TIMEOUT_CYCLES(8)
  ) dut (
    .i_clk       (clk),
    .i_rst_n     (rst_n),
    .i_link_ready(link_ready),
    .i_req_valid (req_valid),
    .o_req_ready (req_ready),
    .i_req_write (req_write),
    .i_req_addr  (req_addr),
    .i_req_wdata (req_wdata),
    .o_rsp_valid (rsp_valid),
    .o_rsp_status(rsp_status),
    .o_rsp_rdata (rsp_rdata),
    .i_dir       (dir),
    .i_nxt       (nxt),
    .i_data      (data_in),
    .o_stp       (stp),
    .o_data      (data_out),
    .o_data_oe   (data_oe)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Present a request; the next tick is the accepting edge.
  task automatic request(input logic wr, input logic [5:0] addr, input logic [7:0] wd);
    req_valid = 1'b1;
    req_write = wr;
    req_addr  = addr;
    req_wdata = wd;
  endtask

  initial begin
    rst_n      = 1'b0;
    link_ready = 1'b1;
    req_valid  = 1'b0;
    req_write  = 1'b0;
    req_addr   = '0;
    req_wdata  = '0;
    dir        = 1'b0;
    nxt        = 1'b0;
    data_in    = '0;
    #12;
    check("reset_ready", req_ready, 0);
    check("reset_rsp_valid", rsp_valid, 0);
    check("reset_oe", data_oe, 0);
    check("reset_data", data_out, 0);
    check("reset_stp", stp, 0);
    rst_n = 1'b1;
    tick();
    check("idle_ready", req_ready, 1);

    // Write 0x55 to 0x0A with immediate nxt: TXCMD, WDATA, STP, RSP.
    request(1'b1, 6'h0A, 8'h55);
    nxt = 1'b1;
    tick();
    req_valid = 1'b0;
    check("wr_txcmd_data", data_out, 8'h8A);
    check("wr_txcmd_oe", data_oe, 1);
    check("wr_txcmd_ready", req_ready, 0);
    tick();
    check("wr_wdata", data_out, 8'h55);
    tick();
    nxt = 1'b0;
    check("wr_stp", stp, 1);
    check("wr_stp_data", data_out, 0);
    check("wr_stp_no_rsp", rsp_valid, 0);
    tick();
    check("wr_rsp_valid", rsp_valid, 1);
    check("wr_rsp_status", rsp_status, 0);
    check("wr_rsp_stp_low", stp, 0);
    tick();
    check("wr_rsp_pulse", rsp_valid, 0);
    check("wr_next_ready", req_ready, 1);

    // Read 0x00: TXCMD, RD_TURN, RD_DATA, RD_BACK, RSP.
    request(1'b0, 6'h00, 8'h00);
    nxt = 1'b1;
    tick();
    req_valid = 1'b0;
    check("rd_txcmd_data", data_out, 8'hC0);
    tick();
    check("rd_turn_oe", data_oe, 0);
    dir = 1'b1;
    nxt = 1'b0;
    data_in = 8'h24;
    tick();
    tick();
    dir = 1'b0;
    data_in = 8'h00;
    check("rd_back_no_rsp", rsp_valid, 0);
    tick();
    check("rd_rsp_valid", rsp_valid, 1);
    check("rd_rsp_status", rsp_status, 0);
    check("rd_rsp_rdata", rsp_rdata, 8'h24);
    tick();
    check("rd_rdata_cleared", rsp_rdata, 0);

    // TX CMD pre-emption for 3 cycles; dir and nxt together on the first, dir wins.
    request(1'b1, 6'h3F, 8'hA5);
    tick();
    req_valid = 1'b0;
    check("pre_txcmd_data", data_out, 8'hBF);
    dir = 1'b1;
    nxt = 1'b1;
    tick();
    nxt = 1'b0;
    check("pre_wait_oe", data_oe, 0);
    tick();
    tick();
    dir = 1'b0;
    check("pre_still_wait_oe", data_oe, 0);
    tick();
    check("pre_retx_data", data_out, 8'hBF);
    check("pre_retx_oe", data_oe, 1);
    nxt = 1'b1;
    tick();
    check("pre_wdata", data_out, 8'hA5);
    tick();
    nxt = 1'b0;
    check("pre_stp", stp, 1);
    tick();
    check("pre_rsp_valid", rsp_valid, 1);
    check("pre_rsp_status", rsp_status, 0);
    tick();

    // Read abort: dir and nxt both high in RD_DATA.
    request(1'b0, 6'h15, 8'h00);
    nxt = 1'b1;
    tick();
    req_valid = 1'b0;
    check("ab_txcmd_data", data_out, 8'hD5);
    tick();
    dir = 1'b1;
    data_in = 8'h77;
    tick();
    tick();
    check("ab_wait_no_rsp", rsp_valid, 0);
    dir = 1'b0;
    nxt = 1'b0;
    data_in = 8'h00;
    tick();
    check("ab_rsp_valid", rsp_valid, 1);
    check("ab_rsp_status", rsp_status, 1);
    check("ab_rsp_rdata", rsp_rdata, 0);
    tick();

`ifdef ULPI_REG_TIMEOUT_EN
    // Timeout after 8 TXCMD cycles with nxt held low.
    request(1'b1, 6'h01, 8'h11);
    tick();
    req_valid = 1'b0;
    for (int i = 0; i < 7; i++) tick();
    check("to_txcmd8_data", data_out, 8'h81);
    check("to_txcmd8_stp", stp, 0);
    tick();
    check("to_stp", stp, 1);
    tick();
    check("to_rsp_valid", rsp_valid, 1);
    check("to_rsp_status", rsp_status, 2);
    tick();
`else
    // Without timeout the engine stays in TXCMD; link_ready drop recovers it.
    request(1'b1, 6'h01, 8'h11);
    tick();
    req_valid = 1'b0;
    for (int i = 0; i < 20; i++) tick();
    check("nto_txcmd_data", data_out, 8'h81);
    check("nto_no_rsp", rsp_valid, 0);
    link_ready = 1'b0;
    tick();
    link_ready = 1'b1;
    check("nto_drop_oe", data_oe, 0);
    tick();
`endif

    // Link-ready drop mid-TXCMD: back to IDLE, no response.
    request(1'b1, 6'h02, 8'h22);
    tick();
    req_valid = 1'b0;
    link_ready = 1'b0;
    tick();
    check("lr_drop_oe", data_oe, 0);
    check("lr_drop_stp", stp, 0);
    check("lr_drop_ready", req_ready, 0);
    request(1'b1, 6'h03, 8'h33);
    tick();
    check("lr_gated_oe", data_oe, 0);
    check("lr_gated_rsp", rsp_valid, 0);
    req_valid = 1'b0;
    link_ready = 1'b1;
    tick();
    check("lr_ready_back", req_ready, 1);

    // dir high in IDLE blocks acceptance.
    dir = 1'b1;
    tick();
    check("dir_blocks_ready", req_ready, 0);
    dir = 1'b0;
    tick();

    // Asynchronous reset in WDATA clears outputs immediately; no response follows.
    request(1'b1, 6'h0A, 8'h5A);
    nxt = 1'b1;
    tick();
    req_valid = 1'b0;
    tick();
    nxt = 1'b0;
    check("rst_pre_wdata", data_out, 8'h5A);
    #2;
    rst_n = 1'b0;
    #1;
    check("rst_async_data", data_out, 0);
    check("rst_async_oe", data_oe, 0);
    check("rst_async_ready", req_ready, 0);
    #2;
    rst_n = 1'b1;
    tick();
    check("rst_no_rsp", rsp_valid, 0);
    check("rst_idle_ready", req_ready, 1);
    tick();
    check("rst_no_stp", stp, 0);

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
